// File: rtl/seq_mul_cla_if.sv
// seq_mul_cla_if
//   Handshake and operand bundle for the iterative multiplier seq_mul_cla.
//   The requester (master) drives start/sign/a/b and watches busy/done/p.
//   The multiplier (slave) consumes the request and returns the product.
//
// Signals:
//   start  request a multiply, only honoured while busy=0
//   sign   1 = signed two's complement operands, 0 = unsigned
//   a      multiplicand, WIDTH bits
//   b      multiplier, WIDTH bits
//   busy   operation in progress
//   done   one-cycle pulse, p has just been updated
//   p      product register, 2*WIDTH bits, held until the next completion
interface seq_mul_cla_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 sign;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;

  modport master (
    output start, sign, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, sign, a, b,
    output busy, done, p
  );
endinterface

// File: rtl/seq_mul_cla.sv
// seq_mul_cla
//   Iterative shift-add multiplier. Signed operands are converted to
//   magnitudes on the start edge, WIDTH accumulation steps run through one
//   WIDTH-bit carry-lookahead adder (4-bit lookahead groups, group carries
//   chained), and a final cycle restores the sign of the 2*WIDTH product.
//   Latency is fixed: start sampled at edge E0, done pulses after E(WIDTH+1).
//
// Ports:
//   clk     clock, all state changes on the rising edge
//   rst     synchronous active-high reset, abandons any operation
//   mulBus  seq_mul_cla_if.slave: start/sign/a/b in, busy/done/p out
//
// WIDTH must be a multiple of 4 because the adder is built from 4-bit groups.
module seq_mul_cla #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH),
  localparam int NG    = WIDTH / 4
) (
  input logic          clk,
  input logic          rst,
  seq_mul_cla_if.slave mulBus
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 neg_q;
  logic [WIDTH-1:0]     mcand_q;
  // The accumulator's carry bit is shifted into hi on every step, so the
  // stored upper half only ever needs WIDTH bits; the extra carry position
  // of the adder output is consumed by the shift.
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   p_q;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     claGen;
  logic [WIDTH-1:0]     claProp;
  logic [WIDTH-1:0]     bitCarry;
  logic [NG:0]          groupCarry;
  logic [3:0]           g4;
  logic [3:0]           p4;
  logic                 c0;
  logic [WIDTH-1:0]     claSum;
  logic                 claCarry;
  logic [WIDTH-1:0]     hi_d;
  logic [WIDTH-1:0]     lo_d;
  logic [2*WIDTH-1:0]   mag;
  logic [2*WIDTH-1:0]   p_d;

  // Adding zero when the multiplier bit is clear gives {0,hi} directly.
  assign addend = lo_q[0] ? mcand_q : '0;

  // Carry-lookahead adder: each 4-bit group resolves its internal carries
  // from generate/propagate terms and produces a group generate/propagate
  // pair, which forms the carry into the next group. Carry-in is zero.
  always_comb begin
    claGen     = hi_q & addend;
    claProp    = hi_q ^ addend;
    groupCarry = '0;
    bitCarry   = '0;
    g4         = '0;
    p4         = '0;
    c0         = 1'b0;
    for (int k = 0; k < NG; k++) begin
      g4 = claGen[4*k +: 4];
      p4 = claProp[4*k +: 4];
      c0 = groupCarry[k];
      bitCarry[4*k]   = c0;
      bitCarry[4*k+1] = g4[0] | (p4[0] & c0);
      bitCarry[4*k+2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & c0);
      bitCarry[4*k+3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                      | (p4[2] & p4[1] & p4[0] & c0);
      groupCarry[k+1] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                      | (p4[3] & p4[2] & p4[1] & g4[0])
                      | (&p4 & c0);
    end
    claSum   = claProp ^ bitCarry;
    claCarry = groupCarry[NG];
  end

  // One step of the shift-add: {hi,lo} = {c,s,lo} >> 1.
  assign hi_d = {claCarry, claSum[WIDTH-1:1]};
  assign lo_d = {claSum[0], lo_q[WIDTH-1:1]};

  // Sign restoration of the unsigned magnitude product.
  assign mag = {hi_q, lo_q};
  assign p_d = neg_q ? -mag : mag;

  // Control FSM and datapath registers. Operands are converted to magnitudes
  // when start is accepted, so later changes on a/b have no effect and a
  // start seen while busy is simply ignored. done is raised only by FIX, so
  // it never coincides with busy, and a reset in RUN leaves no pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (mulBus.start) begin
            neg_q   <= mulBus.sign & (mulBus.a[WIDTH-1] ^ mulBus.b[WIDTH-1]);
            mcand_q <= (mulBus.sign & mulBus.a[WIDTH-1]) ? -mulBus.a : mulBus.a;
            lo_q    <= (mulBus.sign & mulBus.b[WIDTH-1]) ? -mulBus.b : mulBus.b;
            hi_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          p_q     <= p_d;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mulBus.busy = busy_q;
  assign mulBus.done = done_q;
  assign mulBus.p    = p_q;

endmodule
